// File: rtl/fetch_pc_unit_if.sv
// fetch_pc_unit_if
//   Bundles the fetch-stage handshake: hazard/redirect controls and BTB
//   update requests flow into the fetch unit; the fetch PC, BTB hit and
//   IF/ID latch contents flow out.
// Modports
//   master : the surrounding pipeline (drives controls, observes fetch state)
//   slave  : the fetch PC unit (consumes controls, drives fetch state)
// Signals
//   stall, mispredict, corrected_pc, prediction   fetch steering controls
//   upd_en, upd_pc, upd_target                    BTB write request
//   pc, btb_hit                                   current fetch PC and lookup result
//   pc_d, pred_d, valid_d                         IF/ID latch
interface fetch_pc_unit_if #(
  parameter int PC_W = 8
);
  logic            stall;
  logic            mispredict;
  logic [PC_W-1:0] corrected_pc;
  logic            prediction;
  logic            upd_en;
  logic [PC_W-1:0] upd_pc;
  logic [PC_W-1:0] upd_target;
  logic [PC_W-1:0] pc;
  logic            btb_hit;
  logic [PC_W-1:0] pc_d;
  logic            pred_d;
  logic            valid_d;

  modport master (
    output stall, mispredict, corrected_pc, prediction,
    output upd_en, upd_pc, upd_target,
    input  pc, btb_hit, pc_d, pred_d, valid_d
  );

  modport slave (
    input  stall, mispredict, corrected_pc, prediction,
    input  upd_en, upd_pc, upd_target,
    output pc, btb_hit, pc_d, pred_d, valid_d
  );
endinterface

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit
//   Fetch-stage next-PC generator. Holds the fetch PC and a direct-mapped
//   branch target buffer, steers fetch with the BPU prediction gated by a
//   BTB hit, redirects on a mispredict, and registers the fetch PC and the
//   effective taken prediction into the IF/ID latch.
// Ports
//   clk    : clock, all state updates on the rising edge
//   reset  : synchronous active-high reset
//   bus    : fetch_pc_unit_if.slave (controls in, fetch PC / IF/ID out)
//   perf_mispred, perf_btb_taken : saturating 16-bit event counters, present
//            only when FETCH_PERF_CNT_EN is defined
// Configuration
//   FETCH_PERF_CNT_EN : adds the performance counters; when undefined the
//            counters and their ports do not exist.
module fetch_pc_unit #(
  parameter int              PC_W     = 8,
  parameter int              IDX_W    = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                 clk,
  input  logic                 reset,
`ifdef FETCH_PERF_CNT_EN
  output logic [15:0]          perf_mispred,
  output logic [15:0]          perf_btb_taken,
`endif
  fetch_pc_unit_if.slave       bus
);

  localparam int ENTRIES = 1 << IDX_W;
  localparam int TAG_W   = PC_W - IDX_W;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // BTB storage: only the valid bits are control state and see reset.
  logic [ENTRIES-1:0] btb_vld;
  logic [TAG_W-1:0]   btb_tag [ENTRIES];
  logic [PC_W-1:0]    btb_tgt [ENTRIES];

  logic [PC_W-1:0]    pc_p0;
  logic [PC_W-1:0]    pc_p1;
  logic               pred_p1;
  logic               vld_p1;

  logic [IDX_W-1:0]   look_idx;
  logic [TAG_W-1:0]   look_tag;
  logic               hit;
  logic               take;
  logic [PC_W-1:0]    pc_next;
  logic [IDX_W-1:0]   upd_idx;

  // Stage p0: same-cycle BTB lookup and next-PC selection
  always_comb begin
    look_idx = pc_p0[IDX_W-1:0];
    look_tag = pc_p0[PC_W-1:IDX_W];
    hit      = btb_vld[look_idx] && (btb_tag[look_idx] == look_tag);
    // A taken prediction without a BTB target cannot be followed.
    take     = bus.prediction && hit;
    upd_idx  = bus.upd_pc[IDX_W-1:0];
    if (bus.mispredict) begin
      pc_next = bus.corrected_pc;
    end else if (bus.stall) begin
      pc_next = pc_p0;
    end else if (take) begin
      pc_next = btb_tgt[look_idx];
    end else begin
      // Natural width truncation wraps all-ones to zero.
      pc_next = pc_p0 + {{(PC_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_p0 <= RESET_PC;
    end else begin
      pc_p0 <= pc_next;
    end
  end

  // Stage p1: IF/ID latch; a mispredict inserts a bubble even under stall
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_p1   <= '0;
      pred_p1 <= 1'b0;
      vld_p1  <= 1'b0;
    end else if (bus.mispredict) begin
      pc_p1   <= '0;
      pred_p1 <= 1'b0;
      vld_p1  <= 1'b0;
    end else if (!bus.stall) begin
      pc_p1   <= pc_p0;
      pred_p1 <= take;
      vld_p1  <= 1'b1;
    end
  end

  // BTB write port: reads above see the pre-write contents this cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      btb_vld <= '0;
    end else if (bus.upd_en) begin
      btb_vld[upd_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && bus.upd_en) begin
      btb_tag[upd_idx] <= bus.upd_pc[PC_W-1:IDX_W];
      btb_tgt[upd_idx] <= bus.upd_target;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_mispred   <= '0;
      perf_btb_taken <= '0;
    end else begin
      if (bus.mispredict) begin
        perf_mispred <= sat_inc16(perf_mispred);
      end
      if (take && !bus.stall && !bus.mispredict) begin
        perf_btb_taken <= sat_inc16(perf_btb_taken);
      end
    end
  end
`endif

  assign bus.pc      = pc_p0;
  assign bus.btb_hit = hit;
  assign bus.pc_d    = pc_p1;
  assign bus.pred_d  = pred_p1;
  assign bus.valid_d = vld_p1;

endmodule

// File: tb/tb_fetch_pc_unit.sv
module tb_fetch_pc_unit;
  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  fetch_pc_unit_if #(.PC_W(8)) bus ();

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] perf_mispred;
  logic [15:0] perf_btb_taken;
`endif

  fetch_pc_unit #(.PC_W(8), .IDX_W(4), .RESET_PC(8'h00)) dut (
    .clk            (clk),
    .reset          (reset),
`ifdef FETCH_PERF_CNT_EN
    .perf_mispred   (perf_mispred),
    .perf_btb_taken (perf_btb_taken),
`endif
    .bus            (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_if(input string tag, input logic [7:0] pc, input logic [7:0] pcd,
                          input logic predd, input logic vldd);
    check({tag, ".pc"},      {24'd0, bus.pc},      {24'd0, pc});
    check({tag, ".pc_d"},    {24'd0, bus.pc_d},    {24'd0, pcd});
    check({tag, ".pred_d"},  {31'd0, bus.pred_d},  {31'd0, predd});
    check({tag, ".valid_d"}, {31'd0, bus.valid_d}, {31'd0, vldd});
  endtask

  task automatic redirect(input logic [7:0] tgt);
    bus.mispredict   = 1'b1;
    bus.corrected_pc = tgt;
    step();
    bus.mispredict   = 1'b0;
  endtask

  initial begin
    reset            = 1'b1;
    bus.stall        = 1'b0;
    bus.mispredict   = 1'b0;
    bus.corrected_pc = 8'h00;
    bus.prediction   = 1'b0;
    bus.upd_en       = 1'b0;
    bus.upd_pc       = 8'h00;
    bus.upd_target   = 8'h00;
    step();
    step();
    reset = 1'b0;

    // Reset state and free-running fetch
    check_if("rst", 8'h00, 8'h00, 1'b0, 1'b0);
    check("rst.hit", {31'd0, bus.btb_hit}, 32'd0);
    step(); check_if("run1", 8'h01, 8'h00, 1'b0, 1'b1);
    step(); check_if("run2", 8'h02, 8'h01, 1'b0, 1'b1);
    step(); check_if("run3", 8'h03, 8'h02, 1'b0, 1'b1);

    // BTB write for pc=5 then a predicted-taken hit
    bus.upd_en = 1'b1; bus.upd_pc = 8'h05; bus.upd_target = 8'h20;
    step();
    bus.upd_en = 1'b0;
    check("pc4.hit", {31'd0, bus.btb_hit}, 32'd0);
    step();
    bus.prediction = 1'b1;
    check("pc5.hit", {31'd0, bus.btb_hit}, 32'd1);
    step();
    bus.prediction = 1'b0;
    check_if("taken5", 8'h20, 8'h05, 1'b1, 1'b1);

    // Prediction without a BTB entry is not taken
    redirect(8'h07);
    check_if("redir7", 8'h07, 8'h00, 1'b0, 1'b0);
    bus.prediction = 1'b1;
    check("pc7.hit", {31'd0, bus.btb_hit}, 32'd0);
    step();
    bus.prediction = 1'b0;
    check_if("nohit7", 8'h08, 8'h07, 1'b0, 1'b1);

    // Mispredict overrides stall
    bus.stall = 1'b1;
    redirect(8'h40);
    bus.stall = 1'b0;
    check_if("stallmis", 8'h40, 8'h00, 1'b0, 1'b0);
`ifdef FETCH_PERF_CNT_EN
    check("perf_mispred2", {16'd0, perf_mispred}, 32'd2);
`endif
    step();
    check_if("run41", 8'h41, 8'h40, 1'b0, 1'b1);
    bus.stall = 1'b1;
    step();
    step();
    check_if("stall", 8'h41, 8'h40, 1'b0, 1'b1);
    bus.stall = 1'b0;

    // PC wrap at all-ones
    redirect(8'hFF);
    check("pcFF.hit", {31'd0, bus.btb_hit}, 32'd0);
    step();
    check_if("wrap", 8'h00, 8'hFF, 1'b0, 1'b1);

    // Tag mismatch: entry at idx 3 with tag 0, fetch at 0x13
    bus.upd_en = 1'b1; bus.upd_pc = 8'h03; bus.upd_target = 8'h55;
    step();
    bus.upd_en = 1'b0;
    redirect(8'h13);
    bus.prediction = 1'b1;
    check("pc13.hit", {31'd0, bus.btb_hit}, 32'd0);
    step();
    check_if("nohit13", 8'h14, 8'h13, 1'b0, 1'b1);
    bus.prediction = 1'b0;
    redirect(8'h03);
    bus.prediction = 1'b1;
    check("pc3.hit", {31'd0, bus.btb_hit}, 32'd1);
    step();
    bus.prediction = 1'b0;
    check_if("taken3", 8'h55, 8'h03, 1'b1, 1'b1);

    // Write during lookup of the same index: no bypass
    redirect(8'h08);
    step();
    check("pc9", {24'd0, bus.pc}, 32'h09);
    bus.upd_en = 1'b1; bus.upd_pc = 8'h09; bus.upd_target = 8'h30;
    bus.prediction = 1'b1;
    check("pc9.samecyc.hit", {31'd0, bus.btb_hit}, 32'd0);
    step();
    bus.upd_en = 1'b0;
    check_if("pc9.samecyc", 8'h0A, 8'h09, 1'b0, 1'b1);
    redirect(8'h09);
    check("pc9.revisit.hit", {31'd0, bus.btb_hit}, 32'd1);
    step();
    bus.prediction = 1'b0;
    check_if("taken9", 8'h30, 8'h09, 1'b1, 1'b1);
`ifdef FETCH_PERF_CNT_EN
    check("perf_mispred7", {16'd0, perf_mispred}, 32'd7);
    check("perf_taken3", {16'd0, perf_btb_taken}, 32'd3);
`endif

    // Tag conflict overwrites idx 9
    bus.upd_en = 1'b1; bus.upd_pc = 8'h19; bus.upd_target = 8'h77;
    step();
    bus.upd_en = 1'b0;
    redirect(8'h09);
    check("conflict9.hit", {31'd0, bus.btb_hit}, 32'd0);
    redirect(8'h19);
    check("conflict19.hit", {31'd0, bus.btb_hit}, 32'd1);

    // Mid-stream reset discards PC, IF/ID and BTB contents
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_if("rst2", 8'h00, 8'h00, 1'b0, 1'b0);
`ifdef FETCH_PERF_CNT_EN
    check("perf_clr_m", {16'd0, perf_mispred}, 32'd0);
    check("perf_clr_t", {16'd0, perf_btb_taken}, 32'd0);
`endif
    redirect(8'h05);
    check("rst2.pc5.hit", {31'd0, bus.btb_hit}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
